// File: rtl/arm_cond_pkg.sv
// Shared definitions for ARM conditional execution.
//   nzcv_t     : 4-bit status flags packed as {N,Z,C,V}
//   FLAG_*     : bit positions of each flag inside nzcv_t
//   cond_e     : 4-bit instruction condition field encodings COND_EQ..COND_NV
package arm_cond_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition decoder.
// Ports:
//   cond  in  4  instruction condition field
//   nzcv  in  4  flags {N,Z,C,V} to evaluate against
//   pass  out 1  condition holds (0 for the never code, never X)
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
  end

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Issue-side conditional execution controller.
// Holds the architectural NZCV register, evaluates the ID instruction's
// condition, and stalls ID while flag-setting instructions are in flight.
// Optional build macro: COND_FLAG_FWD_EN -- when the last pending flag
// write commits this cycle (and no flush), decode uses the committed data
// directly and the pending-flags stall is lifted for that cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   id_valid       ID holds a valid instruction
//   id_cond        ID condition field
//   id_set_flags   ID instruction sets flags
//   flag_wr_en     older instruction commits flags this cycle
//   flag_wr_data   committed {N,Z,C,V}
//   flush          pipeline flush
//   status_q       architectural {N,Z,C,V}
//   cond_pass      ID condition true
//   stall          hold ID this cycle
//   issue          ID instruction leaves this cycle
//   pend_cnt       in-flight flag-setter count
//   pend_err       sticky: flag write seen with nothing pending
module cond_exec_ctrl
  import arm_cond_pkg::*;
#(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned PCNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_cond,
  input  logic              id_set_flags,
  input  logic              flag_wr_en,
  input  logic [3:0]        flag_wr_data,
  input  logic              flush,
  output logic [3:0]        status_q,
  output logic              cond_pass,
  output logic              stall,
  output logic              issue,
  output logic [PCNT_W-1:0] pend_cnt,
  output logic              pend_err
);

  localparam logic [PCNT_W-1:0] PEND_FULL = PCNT_W'(MAX_PEND);
  localparam logic [PCNT_W-1:0] PEND_ONE  = PCNT_W'(1);

  logic  fwd;
  nzcv_t dec_flags;
  logic  pend_zero;
  logic  stall_flags;
  logic  stall_full;
  logic  inc;
  logic  dec;

  always_comb begin
    pend_zero = (pend_cnt == '0);
`ifdef COND_FLAG_FWD_EN
    fwd = (pend_cnt == PEND_ONE) & flag_wr_en & ~flush;
`else
    fwd = 1'b0;
`endif
    dec_flags = fwd ? flag_wr_data : status_q;
  end

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (dec_flags),
    .pass (cond_pass)
  );

  always_comb begin
    stall_flags = (id_cond != COND_AL) & ~pend_zero & ~fwd;
    stall_full  = id_set_flags & (pend_cnt == PEND_FULL);
    stall       = id_valid & ~flush & (stall_flags | stall_full);
    issue       = id_valid & ~stall & ~flush;
    // A failed-condition instruction writes no flags, so it is not tracked.
    inc         = issue & cond_pass & id_set_flags;
    dec         = flag_wr_en & ~pend_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      pend_cnt <= '0;
      pend_err <= 1'b0;
    end else begin
      // The committing instruction is older than any flush, so its flags land.
      if (flag_wr_en) status_q <= flag_wr_data;

      if (flush)             pend_cnt <= '0;
      else if (inc && !dec)  pend_cnt <= pend_cnt + PEND_ONE;
      else if (dec && !inc)  pend_cnt <= pend_cnt - PEND_ONE;

      if (flag_wr_en && pend_zero && !flush) pend_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
module tb_cond_exec_ctrl;

  localparam int MAX_PEND = 3;
  localparam int PCNT_W   = 3;
`ifdef COND_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid = 1'b0;
  logic [3:0]        id_cond = 4'h0;
  logic              id_set_flags = 1'b0;
  logic              flag_wr_en = 1'b0;
  logic [3:0]        flag_wr_data = 4'h0;
  logic              flush = 1'b0;
  logic [3:0]        status_q;
  logic              cond_pass;
  logic              stall;
  logic              issue;
  logic [PCNT_W-1:0] pend_cnt;
  logic              pend_err;

  int checks = 0;
  int failures = 0;

  cond_exec_ctrl #(.MAX_PEND(MAX_PEND), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond),
    .id_set_flags(id_set_flags), .flag_wr_en(flag_wr_en),
    .flag_wr_data(flag_wr_data), .flush(flush), .status_q(status_q),
    .cond_pass(cond_pass), .stall(stall), .issue(issue),
    .pend_cnt(pend_cnt), .pend_err(pend_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Condition table as a base predicate per pair, odd codes invert it.
  function automatic bit m_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return !c[0];
    endcase
    return base ^ c[0];
  endfunction

  // Reference state
  int       m_pend = 0;
  bit [3:0] m_stat = 0;
  bit       m_err = 0;
  bit       m_init = 0;
  bit       e_stall, e_issue, e_pass;

  task automatic m_outputs();
    bit fw;
    fw = FWD && m_pend == 1 && flag_wr_en && !flush;
    e_pass  = m_eval(id_cond, fw ? flag_wr_data : m_stat);
    e_stall = id_valid && !flush &&
              ((id_cond != 4'hE && m_pend != 0 && !fw) ||
               (id_set_flags && m_pend == MAX_PEND));
    e_issue = id_valid && !e_stall && !flush;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_stat = 0; m_err = 0; m_init = 1;
    end else if (m_init) begin
      m_outputs();
      if (flag_wr_en && m_pend == 0 && !flush) m_err = 1;
      if (flush) m_pend = 0;
      else m_pend = m_pend + int'(e_issue && e_pass && id_set_flags)
                           - int'(flag_wr_en && m_pend != 0);
      if (flag_wr_en) m_stat = flag_wr_data;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      m_outputs();
      chk("m_status", int'(status_q), int'(m_stat));
      chk("m_pend", int'(pend_cnt), m_pend);
      chk("m_err", int'(pend_err), int'(m_err));
      chk("m_stall", int'(stall), int'(e_stall));
      chk("m_issue", int'(issue), int'(e_issue));
      if (id_valid) chk("m_pass", int'(cond_pass), int'(e_pass));
    end
  end

  // Drive one cycle of inputs just after the edge, return at mid-cycle.
  task automatic apply(input bit v, input bit [3:0] c, input bit sf,
                       input bit we, input bit [3:0] wd, input bit fl);
    @(posedge clk); #1;
    rst = 1'b0; id_valid = v; id_cond = c; id_set_flags = sf;
    flag_wr_en = we; flag_wr_data = wd; flush = fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; id_valid = 0; id_cond = 0; id_set_flags = 0;
    flag_wr_en = 0; flag_wr_data = 0; flush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and basic decode
    apply(1, 4'h0, 0, 0, 4'h0, 0);
    chk("rst_status", int'(status_q), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_err", int'(pend_err), 0);
    chk("eq_stall", int'(stall), 0);
    chk("eq_issue", int'(issue), 1);
    chk("eq_pass", int'(cond_pass), 0);
    apply(1, 4'h1, 0, 0, 4'h0, 0);
    chk("ne_pass", int'(cond_pass), 1);

    // ADDS then dependent BEQ
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    chk("adds_issue", int'(issue), 1);
    apply(1, 4'h0, 0, 0, 4'h0, 0);
    chk("beq_pend", int'(pend_cnt), 1);
    chk("beq_stall", int'(stall), 1);
    apply(1, 4'h0, 0, 1, 4'h4, 0);
    chk("beq_wr_stall", int'(stall), FWD ? 0 : 1);
    chk("beq_wr_issue", int'(issue), FWD ? 1 : 0);
    apply(1, 4'h0, 0, 0, 4'h0, 0);
    chk("beq_after_pend", int'(pend_cnt), 0);
    chk("beq_after_stall", int'(stall), 0);
    chk("beq_after_pass", int'(cond_pass), 1);
    chk("beq_after_status", int'(status_q), 4);

    // Fill tracker
    repeat (3) apply(1, 4'hE, 1, 0, 4'h0, 0);
    apply(1, 4'hE, 1, 1, 4'h0, 0);
    chk("full_pend", int'(pend_cnt), 3);
    chk("full_stall", int'(stall), 1);
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    chk("full_rel_pend", int'(pend_cnt), 2);
    chk("full_rel_issue", int'(issue), 1);
    apply(0, 4'h0, 0, 0, 4'h0, 0);
    chk("full_after_pend", int'(pend_cnt), 3);

    // Flush with concurrent flag write
    apply(0, 4'h0, 0, 1, 4'h0, 0);
    apply(0, 4'h0, 0, 1, 4'h9, 1);
    chk("flush_pend_before", int'(pend_cnt), 2);
    chk("flush_issue", int'(issue), 0);
    apply(1, 4'hA, 0, 0, 4'h0, 0);
    chk("flush_pend", int'(pend_cnt), 0);
    chk("flush_status", int'(status_q), 9);
    chk("ge_pass", int'(cond_pass), 1);
    chk("ge_issue", int'(issue), 1);

    // Sticky error on unexpected flag write
    apply(0, 4'h0, 0, 1, 4'h3, 0);
    chk("err_pre", int'(pend_err), 0);
    apply(0, 4'h0, 0, 0, 4'h0, 0);
    chk("err_set", int'(pend_err), 1);
    chk("err_status", int'(status_q), 3);
    apply(0, 4'h0, 0, 0, 4'h0, 0);
    chk("err_sticky", int'(pend_err), 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", int'(pend_err), 0);
    chk("err_rst_status", int'(status_q), 0);

    // Full decode sweep
    for (int f = 0; f < 16; f++) begin
      apply(0, 4'h0, 0, 1, 4'(f), 0);
      for (int c = 0; c < 16; c++) begin
        apply(1, 4'(c), 0, 0, 4'h0, 0);
        if (c == 15) chk("nv_pass", int'(cond_pass), 0);
        if (c == 8 && f == 2) chk("hi_pass", int'(cond_pass), 1);
        if (c == 13 && f == 8) chk("le_pass", int'(cond_pass), 1);
        if (c == 12 && f == 9) chk("gt_pass", int'(cond_pass), 1);
      end
    end

    // Reset mid-operation discards pending state
    do_reset();
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    apply(0, 4'h0, 0, 0, 4'h0, 0);
    chk("mid_pend_pre", int'(pend_cnt), 2);
    do_reset();
    @(negedge clk);
    chk("mid_pend_post", int'(pend_cnt), 0);
    apply(1, 4'h0, 0, 0, 4'h0, 0);
    chk("mid_stall_post", int'(stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- Issue-side controller for conditional execution in the ARM pipeline.
- Owns the architectural NZCV status register and evaluates each ID-stage instruction's 4-bit condition field against it.
- Tracks in-flight flag-setting instructions and stalls ID until the flags a conditional instruction depends on are committed.
- Sits between the ID stage, the hazard unit (stall/flush) and the EXE/flag writeback path.

Parameters:
- MAX_PEND, 3, maximum number of in-flight flag-setting instructions tracked (1..7).
- PCNT_W, 3, width of the pending counter; must satisfy 2**PCNT_W > MAX_PEND.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a valid instruction
- id_cond  input  4  condition field of ID instruction
- id_set_flags  input  1  ID instruction has S bit set
- flag_wr_en  input  1  an older instruction commits flags this cycle
- flag_wr_data  input  4  committed {N,Z,C,V}
- flush  input  1  pipeline flush (branch taken)
- status_q  output  4  architectural {N,Z,C,V}
- cond_pass  output  1  ID instruction's condition true (valid when issue=1)
- stall  output  1  hold ID this cycle
- issue  output  1  id_valid & ~stall & ~flush
- pend_cnt  output  PCNT_W  in-flight flag-setter count
- pend_err  output  1  sticky: flag write seen with pend_cnt==0

Behaviour:
- Reset (rst=1 at clk edge): status_q=4'b0000, pend_cnt=0, pend_err=0. stall/issue/cond_pass are combinational and follow from the reset state.
- Condition decode on {N,Z,C,V} (combinational):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 never, cond_pass=0. No X output for any code.
- Flag source for decode: status_q (see Optional Feature).
- stall=1 iff id_valid & ~flush and either:
  - (a) id_cond!=1110 and pend_cnt!=0 (flags not yet final); or
  - (b) id_set_flags and pend_cnt==MAX_PEND (tracker full).
- AL instructions never stall on (a).
- Issued flag-setter: inc = issue & cond_pass & id_set_flags. A failed-condition instruction sets no flags and is not counted.
- dec = flag_wr_en & (pend_cnt!=0).
- Counter update each edge:
  - flush: pend_cnt <= 0. Younger flag-setters are killed; the same-cycle flag_wr_en is still applied to status_q.
  - else inc&dec: unchanged; inc only: +1; dec only: -1.
- status_q <= flag_wr_data whenever flag_wr_en, regardless of flush or stall.
- flag_wr_en with pend_cnt==0 and no flush: status_q still written, counter stays 0, pend_err <= 1 (sticky until rst).
- Reset mid-operation: all pending state discarded; the first post-reset cycle sees pend_cnt=0.
- Latency: a flag write at edge k is visible to decode in cycle k+1. A stalled conditional instruction issues in the first cycle where pend_cnt==0.

Optional Feature:
- Macro: COND_FLAG_FWD_EN.
- Defined: when pend_cnt==1 & flag_wr_en & ~flush, decode uses flag_wr_data instead of status_q, and stall condition (a) is suppressed for that cycle. The instruction issues in the same cycle the flags commit, saving one cycle per dependency.
- Undefined: decode always uses status_q; stall per (a) as written.
- Counter, status_q and pend_err behaviour are identical in both builds.

Decomposition:
- Shared package arm_cond_pkg:
  - 4-bit condition code constants COND_EQ..COND_NV.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Typedef nzcv_t (logic [3:0]).
- One sub-module: cond_eval, the pure combinational 16-way condition decoder (cond, nzcv -> pass), instantiated once.
- Counter, status register and stall logic stay in cond_exec_ctrl.

Test Plan:
- Reset, then id_valid=1, id_cond=0000 (EQ), status 0000 -> stall=0, issue=1, cond_pass=0; id_cond=0001 -> cond_pass=1.
- Issue ADDS (cond 1110, set_flags=1) -> pend_cnt=1. Next cycle BEQ (cond 0000) -> stall=1. flag_wr_en with data 0100 -> next cycle pend_cnt=0, stall=0, cond_pass=1, status_q=0100. With COND_FLAG_FWD_EN: issue happens in the write cycle itself.
- Issue 3 flag-setters (MAX_PEND=3) -> pend_cnt=3; 4th with set_flags -> stall=1. A same-cycle flag_wr_en does not release it that cycle; it issues the cycle after, pend_cnt stays 3.
- pend_cnt=2, flush=1 with flag_wr_en data 1001 -> pend_cnt=0, status_q=1001, issue=0; a following GE (cond 1010) -> cond_pass=1.
- flag_wr_en with pend_cnt=0 -> pend_err=1 and stays 1; status_q updated; rst clears pend_err.
- Sweep all 16 id_cond × 16 NZCV values with pend_cnt=0 -> cond_pass matches the decode table; code 1111 always 0.
